exu_alu_mc: RTL and testbench

Parametrised multi-cycle integer execute unit for the NPC core.
- Executes the full RV32I OP-IMM (0010011) and OP (0110011) ALU function sets.
- Input and output use valid/ready handshakes; the result is held in an output register.
- Shifts use an iterative shifter, one bit per cycle.
- Sits between the decode stage and the writeback stage.

---
 rtl/exu_alu_mc.sv | 171 +++++++++++++++++
 tb/tb_exu_alu_mc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_alu_mc.sv
// exu_alu_mc: multi-cycle RV32I OP / OP-IMM integer execute unit.
// Valid/ready on both sides, result held in an output register.
// Shifts run on an iterative one-bit-per-cycle shifter by default.
// Build option: define EXU_FAST_SHIFT_EN to use a single-cycle barrel
// shifter instead (SHIFT state never entered, busy tied low).
module exu_alu_mc #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_op,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [IMM_W-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_illegal,
  output logic             busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shkind_e;

  // Registered state
  state_e          state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;      // shift working value, then result
  logic [SHW-1:0]  cnt_q, cnt_d;        // remaining shift steps
  shkind_e         kind_q, kind_d;
  logic            illegal_q, illegal_d;
  logic            busy_q, busy_d;

  // Request decode
  logic                    is_op, is_opimm, illegal, is_shift, go_iter, accept;
  logic signed [IMM_W-1:0] imm_s;
  logic [XLEN-1:0]         imm_ext, opb, alu_res, sh_res, step_res;
  logic [SHW-1:0]          shamt;
  shkind_e                 kind;

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Decode the incoming request and compute the single-cycle result
  always_comb begin
    is_op    = (in_op == OPC_OP);
    is_opimm = (in_op == OPC_OP_IMM);
    imm_s    = in_imm;
    imm_ext  = XLEN'(imm_s);
    opb      = is_op ? in_src2 : imm_ext;
    shamt    = opb[SHW-1:0];
    illegal  = !(is_op || is_opimm) ||
               (is_opimm && (in_funct3 == 3'b001) && in_funct7b5);
    is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    if (in_funct3 == 3'b101) kind = in_funct7b5 ? SH_SRA : SH_SRL;
    else                     kind = SH_SLL;
`ifdef EXU_FAST_SHIFT_EN
    // Barrel shifter: every shift completes on the accept edge.
    go_iter = 1'b0;
    case (kind)
      SH_SRL:  sh_res = in_src1 >> shamt;
      SH_SRA:  sh_res = XLEN'($signed(in_src1) >>> shamt);
      default: sh_res = in_src1 << shamt;
    endcase
`else
    // Iterative shifter: only a zero-distance shift finishes immediately.
    go_iter = is_shift && (shamt != '0);
    sh_res  = in_src1;
`endif
    case (in_funct3)
      3'b000:  alu_res = (is_op && in_funct7b5) ? (in_src1 - opb) : (in_src1 + opb);
      3'b010:  alu_res = XLEN'($signed(in_src1) < $signed(opb));
      3'b011:  alu_res = XLEN'(in_src1 < opb);
      3'b100:  alu_res = in_src1 ^ opb;
      3'b110:  alu_res = in_src1 | opb;
      3'b111:  alu_res = in_src1 & opb;
      default: alu_res = sh_res;     // 001 / 101: shifts
    endcase
  end

  // One-bit shift step applied to the working register in SHIFT
  always_comb begin
    case (kind_q)
      SH_SRL:  step_res = {1'b0, work_q[XLEN-1:1]};
      SH_SRA:  step_res = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: step_res = {work_q[XLEN-2:0], 1'b0};
    endcase
  end

  // Next-state logic: state progression, then a new accept overrides it
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    illegal_d = illegal_q;
    case (state_q)
      S_SHIFT: begin
        work_d = step_res;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      illegal_d = illegal;
      kind_d    = kind;
      if (illegal) begin
        work_d  = '0;
        state_d = S_DONE;
      end else if (go_iter) begin
        work_d  = in_src1;
        cnt_d   = shamt;
        state_d = S_SHIFT;
      end else begin
        work_d  = alu_res;
        state_d = S_DONE;
      end
    end
    busy_d = (state_d == S_SHIFT);
  end

  // State and output registers; reset aborts any shift in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      kind_q    <= SH_SLL;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
    end
  end

  assign out_valid   = (state_q == S_DONE);
  assign out_result  = work_q;
  assign out_illegal = illegal_q;
`ifdef EXU_FAST_SHIFT_EN
  assign busy = 1'b0;
`else
  assign busy = busy_q;
`endif

endmodule

// File: tb/tb_exu_alu_mc.sv
// tb_exu_alu_mc: directed + randomized checks of exu_alu_mc against a
// behavioural model of the RV32I OP / OP-IMM rules.
module tb_exu_alu_mc;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_OPI = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
`ifdef EXU_FAST_SHIFT_EN
  localparam logic ITER = 1'b0;
`else
  localparam logic ITER = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  in_op;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_src1, in_src2;
  logic [11:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_illegal, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exu_alu_mc #(.XLEN(32), .IMM_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_illegal(out_illegal), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Behavioural model: illegal flag, result and accept-to-valid latency
  function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [31:0] s1, input logic [31:0] s2,
                                input logic [11:0] imm,
                                output logic ill, output logic [31:0] res, output int lat);
    logic [31:0] b;
    int sh;
    ill = 1'b0;
    res = 32'h0;
    lat = 1;
    if (op != OPC_OP && op != OPC_OPI) begin ill = 1'b1; return; end
    if (op == OPC_OPI && f3 == 3'b001 && f7) begin ill = 1'b1; return; end
    b  = (op == OPC_OP) ? s2 : {{20{imm[11]}}, imm};
    sh = int'(b & 32'd31);
    case (f3)
      3'd0: res = (op == OPC_OP && f7) ? s1 - b : s1 + b;
      3'd1: res = s1 << sh;
      3'd2: res = ($signed(s1) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: res = (s1 < b) ? 32'd1 : 32'd0;
      3'd4: res = s1 ^ b;
      3'd5: res = f7 ? 32'($signed(s1) >>> sh) : s1 >> sh;
      3'd6: res = s1 | b;
      default: res = s1 & b;
    endcase
    if (ITER && (f3 == 3'd1 || f3 == 3'd5)) lat = 1 + sh;
  endfunction

  task automatic set_bus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] s1, input logic [31:0] s2, input logic [11:0] imm);
    in_op = op; in_funct3 = f3; in_funct7b5 = f7;
    in_src1 = s1; in_src2 = s2; in_imm = imm;
  endtask

  // Issue one request, hold junk on the input bus while waiting, then consume
  task automatic run_one(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [11:0] imm, output logic [31:0] got);
    logic        e_ill;
    logic [31:0] e_res;
    int          e_lat, lat;
    logic        seen;
    model(op, f3, f7, s1, s2, imm, e_ill, e_res, e_lat);
    @(negedge clk);
    check1({tag, ":in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    set_bus(op, f3, f7, s1, s2, imm);
    @(posedge clk);
    #1;
    set_bus(OPC_OP, 3'b000, 1'b0, $urandom, $urandom, 12'($urandom));
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 64) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        lat++;
        check1({tag, ":busy"}, busy, ITER);
        check1({tag, ":in_ready_shift"}, in_ready, 1'b0);
      end
    end
    check1({tag, ":timeout"}, seen, 1'b1);
    check({tag, ":latency"}, 32'(lat), 32'(e_lat));
    check({tag, ":result"}, out_result, e_res);
    check1({tag, ":illegal"}, out_illegal, e_ill);
    check1({tag, ":in_ready_done"}, in_ready, 1'b0);
    $display("%s op=%h f3=%0d f7=%0d s1=%h s2=%h imm=%h -> res=%h ill=%0d lat=%0d",
             tag, op, f3, f7, s1, s2, imm, out_result, out_illegal, lat);
    got       = out_result;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check1({tag, ":drained"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] sa[4], sb[4], se[4];
    logic        e_ill, seen;
    int          e_lat;
    logic [6:0]  rop;
    logic [6:0]  bad_ops[3];

    bad_ops[0] = OPC_LD; bad_ops[1] = 7'b1100011; bad_ops[2] = 7'b0110111;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_bus(7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 12'h0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst:out_valid", out_valid, 1'b0);
    check1("rst:in_ready", in_ready, 1'b1);
    check1("rst:busy", busy, 1'b0);
    check("rst:out_result", out_result, 32'h0);
    check1("rst:out_illegal", out_illegal, 1'b0);
    rst_n = 1'b1;

    // Directed operations
    run_one("addi", OPC_OPI, 3'b000, 1'b0, 32'h5, 32'h0, 12'hFFF, got);
    check("addi:const", got, 32'h4);
    run_one("sub", OPC_OP, 3'b000, 1'b1, 32'd3, 32'd5, 12'h0, got);
    check("sub:const", got, 32'hFFFFFFFE);
    run_one("slt", OPC_OP, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 12'h0, got);
    check("slt:const", got, 32'h1);
    run_one("sltu", OPC_OP, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 12'h0, got);
    check("sltu:const", got, 32'h0);
    run_one("srai4", OPC_OPI, 3'b101, 1'b1, 32'h80000000, 32'h0, 12'd4, got);
    check("srai4:const", got, 32'hF8000000);
    run_one("illegal_ld", OPC_LD, 3'b000, 1'b0, $urandom, $urandom, 12'($urandom), got);
    run_one("illegal_slli", OPC_OPI, 3'b001, 1'b1, $urandom, 32'h0, 12'd3, got);
    run_one("srli31", OPC_OPI, 3'b101, 1'b0, $urandom, 32'h0, 12'd31, got);
    run_one("slli0", OPC_OPI, 3'b001, 1'b0, $urandom, 32'h0, 12'h0, got);
    run_one("sra_op", OPC_OP, 3'b101, 1'b1, 32'h9000_0001, 32'hFFFF_FFE3, 12'h0, got);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:          rop = bad_ops[$urandom_range(0, 2)];
        1, 2, 3, 4: rop = OPC_OPI;
        default:    rop = OPC_OP;
      endcase
      run_one($sformatf("rnd%0d", i), rop, 3'($urandom), 1'($urandom),
              $urandom, $urandom, 12'($urandom), got);
    end

    // Backpressure, then back-to-back ADDs with in_valid held
    for (int k = 0; k < 4; k++) begin
      sa[k] = $urandom; sb[k] = $urandom;
      model(OPC_OP, 3'b000, 1'b0, sa[k], sb[k], 12'h0, e_ill, se[k], e_lat);
    end
    @(negedge clk);
    in_valid = 1'b1;
    set_bus(OPC_OP, 3'b000, 1'b0, sa[0], sb[0], 12'h0);
    @(posedge clk);
    #1;
    set_bus(OPC_OP, 3'b000, 1'b0, sa[1], sb[1], 12'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check1("bp:out_valid", out_valid, 1'b1);
      check("bp:result", out_result, se[0]);
      check1("bp:in_ready", in_ready, 1'b0);
      $display("bp cycle %0d result=%h in_ready=%0d", c, out_result, in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        check1("stream:out_valid", out_valid, 1'b1);
        check("stream:result", out_result, se[k]);
        check1("stream:in_ready", in_ready, 1'b1);
        $display("stream %0d result=%h", k, out_result);
      end
      @(posedge clk);
      #1;
      if (k + 2 < 4) set_bus(OPC_OP, 3'b000, 1'b0, sa[k+2], sb[k+2], 12'h0);
      else           in_valid = 1'b0;
    end
    @(negedge clk);
    check1("stream:drained", out_valid, 1'b0);
    out_ready = 1'b0;

    // Reset in the middle of a 20-bit SLL
    @(negedge clk);
    check1("midrst:in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    set_bus(OPC_OP, 3'b001, 1'b0, $urandom, 32'd20, 12'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check1("midrst:busy_before", busy, ITER);
    check1("midrst:valid_before", out_valid, ~ITER);
    rst_n = 1'b0;
    #1;
    check1("midrst:out_valid", out_valid, 1'b0);
    check1("midrst:busy", busy, 1'b0);
    check1("midrst:in_ready", in_ready, 1'b1);
    check("midrst:result", out_result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check1("midrst:no_output", seen, 1'b0);
    $display("midrst done busy=%0d out_valid_seen=%0d", busy, seen);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
